// File: rtl/dw2_gen.sv
// Layer-2 delta-weight producer: dw = -sat(sat(sat(err*deriv)*act)*LR), all Q5.10,
// computed on one shared multiplier; define DW2_GEN_DW_CLIP_EN to clamp dw to +/-DW_MAX.
module dw2_gen #(
  parameter logic signed [15:0] LR     = 16'sd512,
  parameter logic signed [15:0] DW_MAX = 16'sd205
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               init_req,
  input  logic signed [15:0] err,
  input  logic signed [15:0] deriv,
  input  logic signed [15:0] act,
  output logic signed [15:0] dw,
  output logic signed [15:0] delta2,
  output logic               select_update,
  output logic               select_initial,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {IDLE, MUL1, MUL2, MUL3, DONE} state_t;

  state_t             state, state_nx;
  logic signed [15:0] err_r, deriv_r, act_r, delta_r, p_r;
  logic signed [15:0] mul_a, mul_b, prod_sat;
  logic signed [31:0] prod;
  logic               capture, init_fire;

  if (DW_MAX <= 16'sd0) begin : g_bad_dw_max
    $error("dw2_gen: DW_MAX must be positive");
  end

  // Q5.10 product back to Q5.10: floor shift, then clamp to 16 bits.
  function automatic logic signed [15:0] sat_q10(input logic signed [31:0] x);
    logic signed [31:0] sh;
    sh = x >>> 10;
    if (sh > 32'sd32767)       return 16'sh7fff;
    else if (sh < -32'sd32768) return 16'sh8000;
    else                       return sh[15:0];
  endfunction

  function automatic logic signed [15:0] neg_sat(input logic signed [15:0] x);
    if (x == 16'sh8000) return 16'sh7fff;
    else                return 16'(-x);
  endfunction

  function automatic logic signed [15:0] clip_dw(input logic signed [15:0] x);
`ifdef DW2_GEN_DW_CLIP_EN
    if (x > DW_MAX)       return DW_MAX;
    else if (x < -DW_MAX) return 16'(-DW_MAX);
    else                  return x;
`else
    return x;
`endif
  endfunction

  assign prod     = 32'(mul_a) * 32'(mul_b);
  assign prod_sat = sat_q10(prod);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_nx      = state;
    mul_a         = err_r;
    mul_b         = deriv_r;
    busy          = (state != IDLE);
    select_update = 1'b0;
    done          = 1'b0;
    capture       = 1'b0;
    init_fire     = 1'b0;
    case (state)
      IDLE: begin
        if (init_req) begin
          init_fire = 1'b1;
        end else if (start) begin
          capture  = 1'b1;
          state_nx = MUL1;
        end
      end
      MUL1: state_nx = MUL2;
      MUL2: begin
        mul_a    = delta_r;
        mul_b    = act_r;
        state_nx = MUL3;
      end
      MUL3: begin
        mul_a    = p_r;
        mul_b    = LR;
        state_nx = DONE;
      end
      DONE: begin
        select_update = 1'b1;
        done          = 1'b1;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The last product lands directly in dw so it is valid throughout DONE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: all datapath registers are cleared so an aborted update leaves nothing behind.
      err_r          <= '0;
      deriv_r        <= '0;
      act_r          <= '0;
      delta_r        <= '0;
      p_r            <= '0;
      dw             <= '0;
      delta2         <= '0;
      select_initial <= 1'b0;
    end else begin
      select_initial <= init_fire;
      if (capture) begin
        err_r   <= err;
        deriv_r <= deriv;
        act_r   <= act;
      end
      case (state)
        MUL1: delta_r <= prod_sat;
        MUL2: p_r     <= prod_sat;
        MUL3: begin
          dw     <= clip_dw(neg_sat(prod_sat));
          delta2 <= delta_r;
        end
        default: ;
      endcase
    end
  end

endmodule
